stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- N-to-1 packet arbiter for the valid/ready/data streaming protocol. It shares one downstream stream (the shared stream_fifo write port) between NUM_SRC upstream sources.
- Round-robin arbitration with a grant lock that holds until the end of the current packet (last beat).
- Single-entry registered output stage: 1-cycle latency, full throughput.

Parameters:
- NUM_SRC, 4, number of upstream sources (2..16).
- DATA_WIDTH, 8, payload width per beat.
- SRC_W, $clog2(NUM_SRC), width of the source-id field (derived, not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  NUM_SRC  per-source beat valid.
- s_ready  output  NUM_SRC  per-source beat accept.
- s_data  input  NUM_SRC*DATA_WIDTH  per-source payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_last  input  NUM_SRC  per-source end-of-packet flag.
- m_valid  output  1  downstream beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  downstream payload.
- m_last  output  1  downstream end-of-packet.
- m_src  output  SRC_W  id of the source that produced the current m_data.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - m_valid=0, m_data=0, m_last=0, m_src=0, busy=0.
  - state=IDLE, last_grant=NUM_SRC-1, so source 0 has first priority.
- Output register:
  - can_accept = !m_valid || m_ready.
  - An input beat accepted at edge k appears on m_* after edge k; latency 1 cycle.
  - If m_valid && !m_ready, m_* hold stable.
  - If m_valid && m_ready and no new beat is accepted, m_valid goes to 0 at the next edge.
  - Back-to-back streaming is sustained at 1 beat/cycle while m_ready=1.
- Selection (combinational):
  - IDLE: sel = first i with s_valid[i]=1, searching i = last_grant+1, last_grant+2, ... mod NUM_SRC. No valid source means no selection.
  - LOCKED: sel = lock_id only. s_valid from other sources is ignored.
- s_ready[i] = can_accept && (i==sel) && s_valid[sel] (IDLE) or (i==lock_id) (LOCKED). At most one s_ready bit is high in any cycle.
- Combinational path from m_ready to s_ready is permitted.
- Accepted beat (s_valid[sel] && s_ready[sel]) loads m_data, m_last, m_src=sel and sets m_valid=1.
- State transitions on an accepted beat:
  - IDLE, s_last=1: stay IDLE, last_grant<=sel (single-beat packet).
  - IDLE, s_last=0: go to LOCKED, lock_id<=sel.
  - LOCKED, s_last=1: go to IDLE, last_grant<=lock_id.
  - LOCKED, s_last=0: stay LOCKED.
- Locked source idle: if the locked source drops s_valid mid-packet, the arbiter stays LOCKED (holds the bus, inserts bubbles). No timeout.
- Pointer update: last_grant updates only at packet end, so fairness is per packet, not per beat.
- NUM_SRC not a power of 2: the search wraps at NUM_SRC. Ids >= NUM_SRC are never produced.
- Reset mid-packet: the locked packet is abandoned, the beat held in the output register is dropped (m_valid=0 next cycle), and the pointer returns to NUM_SRC-1.
- Source protocol (bench asserts it, RTL does not check it): once s_valid[i] is high, data and last hold until s_ready[i].

Test Plan:
- Reset then single source: src2 sends 1 beat 0xA5 with last=1, m_ready=1. Expected: s_ready[2]=1 the same cycle; m_valid=1, m_data=0xA5, m_src=2, m_last=1 one cycle later; busy stays 0.
- Round-robin: all 4 sources continuously offer single-beat packets (data=0x10+i), m_ready=1. Expected: m_src order is 0,1,2,3,0,1,..., one beat per cycle with no bubbles.
- Packet lock: src1 sends 3-beat packet 0x01,0x02,0x03 (last on the third beat) while src0 and src3 are valid. Expected: three consecutive src1 beats with busy=1 throughout, then src3 granted next (pointer after 1), then src0.
- Backpressure: src0 streams 0x00..0x07 and m_ready toggles 1,0,0,1,... Expected: m_data stable while m_ready=0, every beat delivered exactly once in order, s_ready[0]=0 whenever m_valid=1 and m_ready=0.
- Locked source stalls: src2 sends beat 0x20 with last=0, then drops s_valid for 3 cycles while src0 is valid. Expected: src0 is never granted; src2's following beat 0x21 with last=1 is accepted, then src0 is granted.
- Reset mid-packet: assert rst while LOCKED on src1 with m_valid=1 and m_ready=0. Expected: next cycle m_valid=0 and busy=0; first grant after reset goes to src0 if src0 and src1 are both valid.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin packet arbiter for valid/ready streams.
// A grant stays locked to one source until its last beat; a single registered stage drives the output.
module stream_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            s_valid,
  output logic [NUM_SRC-1:0]            s_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SRC-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [SRC_W-1:0]              m_src,
  output logic                          busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      last_grant_next;
  logic [SRC_W-1:0]      lock_id;
  logic [SRC_W-1:0]      lock_id_next;

  logic [SRC_W-1:0]      cand;
  logic                  hit;
  logic [SRC_W-1:0]      sel;
  logic                  sel_found;
  logic [SRC_W-1:0]      grant;
  logic                  grant_valid;
  logic                  can_accept;
  logic                  accept;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_last;

  // Rotating-priority search that starts just after the owner of the last finished packet.
  always_comb begin
    cand      = '0;
    hit       = 1'b0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand      = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      hit       = s_valid[cand] && !sel_found;
      sel       = hit ? cand : sel;
      sel_found = sel_found || hit;
    end
  end

  assign can_accept  = !m_valid || m_ready;
  assign grant       = (state == LOCKED) ? lock_id : sel;
  assign grant_valid = (state == LOCKED) ? 1'b1 : sel_found;
  assign grant_data  = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_last  = s_last[grant];
  assign accept      = can_accept && grant_valid && s_valid[grant];

  // One-hot ready towards the granted source; the locked source gets ready even while idle.
  always_comb begin
    s_ready = '0;
    if (can_accept && grant_valid) begin
      s_ready[grant] = 1'b1;
    end else begin
      s_ready = '0;
    end
  end

  // Lock on a non-final beat; the fairness pointer only moves at packet end.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    lock_id_next    = lock_id;
    case (state)
      IDLE: begin
        if (accept && !grant_last) begin
          state_next   = LOCKED;
          lock_id_next = grant;
        end else if (accept) begin
          last_grant_next = grant;
        end else begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (accept && grant_last) begin
          state_next      = IDLE;
          last_grant_next = lock_id;
        end else begin
          state_next = LOCKED;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(NUM_SRC - 1);
      lock_id    <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      lock_id    <= lock_id_next;
    end
  end

  // Output stage: load on accept, drain on downstream ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= grant_data;
      m_last  <= grant_last;
      m_src   <= grant;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= m_valid;
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a packet-level round-robin reference model.
module tb_stream_rr_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int SRC_W      = 2;
  localparam int QD         = 64;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_SRC-1:0]            s_valid;
  logic [NUM_SRC-1:0]            s_ready;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
  logic [NUM_SRC-1:0]            s_last;
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_last;
  logic [SRC_W-1:0]              m_src;
  logic                          busy;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-source beat queues {last, data}; a source holds its head beat until handshaken.
  logic [8:0]         mem [NUM_SRC][QD];
  int                 head [NUM_SRC];
  int                 tail [NUM_SRC];
  logic [NUM_SRC-1:0] allow;
  int                 acc_src;
  logic [31:0]        del_q[$];   // delivered beats: {src, last, data}
  logic               prev_stall;
  logic [31:0]        prev_out;

  // Reference model: packet owner (-1 when none), pointer, and the output register contents.
  int                 mdl_lock;
  int                 mdl_ptr;
  logic               mdl_mv;
  logic [7:0]         mdl_md;
  logic               mdl_ml;
  int                 mdl_ms;

  task automatic mdl_reset();
    mdl_lock = -1;
    mdl_ptr  = NUM_SRC - 1;
    mdl_mv   = 1'b0;
    mdl_md   = 8'h00;
    mdl_ml   = 1'b0;
    mdl_ms   = 0;
  endtask

  function automatic int mdl_pick(input logic [NUM_SRC-1:0] v);
    if (mdl_lock >= 0) return mdl_lock;
    for (int n = 1; n <= NUM_SRC; n++)
      if (v[(mdl_ptr + n) % NUM_SRC]) return (mdl_ptr + n) % NUM_SRC;
    return -1;
  endfunction

  function automatic logic [31:0] del_at(input int k);
    return (k < del_q.size()) ? del_q[k] : 32'hFFFF_FFFF;
  endfunction

  task automatic push_beat(input int s, input logic [7:0] d, input logic l);
    mem[s][tail[s] % QD] = {l, d};
    tail[s]++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NUM_SRC; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    s_valid = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!(s_valid[i] && acc_src != i)) begin
        s_valid[i] = (tail[i] != head[i]) && allow[i];
        {s_last[i], s_data[i*DATA_WIDTH +: DATA_WIDTH]} = mem[i][head[i] % QD];
      end
    end
  endtask

  task automatic cycle();
    logic [NUM_SRC-1:0] exp_rdy;
    int                 g;
    logic               room;
    logic               take;
    logic [7:0]         d;
    logic               l;
    @(negedge clk);
    check_eq("m_valid", m_valid, mdl_mv);
    check_eq("m_data", m_data, mdl_md);
    check_eq("m_last", m_last, mdl_ml);
    check_eq("m_src", m_src, mdl_ms);
    check_eq("busy", busy, mdl_lock >= 0);
    g       = mdl_pick(s_valid);
    room    = !mdl_mv || m_ready;
    exp_rdy = '0;
    if (room && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("s_ready", s_ready, exp_rdy);
    if (m_valid === 1'b1 && m_ready === 1'b0) check_eq("stall_ready", s_ready, 0);
    if (prev_stall) check_eq("hold", {m_src, m_last, m_data}, prev_out);
    prev_stall = (m_valid === 1'b1) && !m_ready && !rst;
    prev_out   = {m_src, m_last, m_data};
    acc_src    = -1;
    if (!rst)
      for (int i = 0; i < NUM_SRC; i++)
        if (s_valid[i] && s_ready[i] === 1'b1) acc_src = i;
    if (!rst && m_valid === 1'b1 && m_ready) del_q.push_back({m_src, m_last, m_data});
    take = room && g >= 0 && s_valid[g];
    d    = 8'h00;
    l    = 1'b0;
    if (take) begin
      d = s_data[g*DATA_WIDTH +: DATA_WIDTH];
      l = s_last[g];
    end
    @(posedge clk);
    if (rst) begin
      mdl_reset();
    end else if (take) begin
      mdl_mv = 1'b1;
      mdl_md = d;
      mdl_ml = l;
      mdl_ms = g;
      if (l) begin
        mdl_lock = -1;
        mdl_ptr  = g;
      end else begin
        mdl_lock = g;
      end
    end else if (m_ready) begin
      mdl_mv = 1'b0;
    end
    #1;
    if (acc_src >= 0) head[acc_src]++;
    drive();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    allow = '0;
    clear_srcs();
    cycle();
    rst = 1'b0;
    del_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    m_ready    = 1'b0;
    s_valid    = '0;
    s_data     = '0;
    s_last     = '0;
    allow      = '0;
    acc_src    = -1;
    prev_stall = 1'b0;
    prev_out   = 32'h0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int j = 0; j < QD; j++) mem[i][j] = 9'h000;
    clear_srcs();
    @(posedge clk);
    #1;
    mdl_reset();
    cycle();
    rst = 1'b0;

    // Single beat from source 2.
    do_reset();
    m_ready = 1'b1;
    push_beat(2, 8'hA5, 1'b1);
    allow = 4'b0100;
    drive();
    cycle();
    check_eq("t1_ready", acc_src, 2);
    cycle();
    check_eq("t1_beat", del_at(0), {2'd2, 1'b1, 8'hA5});
    check_eq("t1_busy", busy, 1'b0);

    // Round robin over four sources offering single-beat packets.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++)
      for (int r = 0; r < 4; r++) push_beat(i, 8'h10 + 8'(i), 1'b1);
    allow = 4'b1111;
    drive();
    repeat (12) cycle();
    check_eq("t2_count", del_q.size(), 11);
    for (int k = 0; k < 11; k++)
      check_eq("t2_order", del_at(k), {2'(k % 4), 1'b1, 8'h10 + 8'(k % 4)});

    // Packet lock: source 1 three-beat packet competes with sources 0 and 3.
    do_reset();
    m_ready = 1'b1;
    push_beat(0, 8'h40, 1'b1);
    allow = 4'b0001;
    drive();
    cycle();
    push_beat(1, 8'h01, 1'b0);
    push_beat(1, 8'h02, 1'b0);
    push_beat(1, 8'h03, 1'b1);
    push_beat(3, 8'h33, 1'b1);
    push_beat(0, 8'h41, 1'b1);
    allow = 4'b1111;
    drive();
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (c == 0 || c == 1) check_eq("t3_busy", busy, 1'b1);
    end
    check_eq("t3_count", del_q.size(), 6);
    check_eq("t3_b0", del_at(0), {2'd0, 1'b1, 8'h40});
    check_eq("t3_b1", del_at(1), {2'd1, 1'b0, 8'h01});
    check_eq("t3_b2", del_at(2), {2'd1, 1'b0, 8'h02});
    check_eq("t3_b3", del_at(3), {2'd1, 1'b1, 8'h03});
    check_eq("t3_b4", del_at(4), {2'd3, 1'b1, 8'h33});
    check_eq("t3_b5", del_at(5), {2'd0, 1'b1, 8'h41});

    // Backpressure on a continuous source 0 stream.
    do_reset();
    for (int k = 0; k < 8; k++) push_beat(0, 8'(k), 1'b1);
    allow = 4'b0001;
    drive();
    for (int c = 0; c < 40 && del_q.size() < 8; c++) begin
      m_ready = (c % 3 == 0);
      cycle();
    end
    check_eq("t4_count", del_q.size(), 8);
    for (int k = 0; k < 8; k++) check_eq("t4_order", del_at(k), {2'd0, 1'b1, 8'(k)});

    // Locked source 2 goes idle mid-packet while source 0 waits.
    do_reset();
    m_ready = 1'b1;
    push_beat(1, 8'h11, 1'b1);
    allow = 4'b0010;
    drive();
    cycle();
    push_beat(2, 8'h20, 1'b0);
    push_beat(2, 8'h21, 1'b1);
    push_beat(0, 8'h50, 1'b1);
    allow = 4'b0101;
    drive();
    cycle();
    check_eq("t5_lock", acc_src, 2);
    allow = 4'b0001;
    drive();
    repeat (3) begin
      cycle();
      check_eq("t5_busy", busy, 1'b1);
      check_eq("t5_nogrant", acc_src, -1);
    end
    allow = 4'b0101;
    drive();
    cycle();
    check_eq("t5_resume", acc_src, 2);
    cycle();
    check_eq("t5_next", acc_src, 0);
    cycle();
    check_eq("t5_count", del_q.size(), 4);
    check_eq("t5_b1", del_at(1), {2'd2, 1'b0, 8'h20});
    check_eq("t5_b2", del_at(2), {2'd2, 1'b1, 8'h21});
    check_eq("t5_b3", del_at(3), {2'd0, 1'b1, 8'h50});

    // Reset while locked with a stalled output beat.
    do_reset();
    m_ready = 1'b0;
    push_beat(1, 8'h61, 1'b0);
    push_beat(1, 8'h62, 1'b0);
    push_beat(1, 8'h63, 1'b1);
    push_beat(0, 8'h70, 1'b1);
    allow = 4'b0010;
    drive();
    cycle();
    check_eq("t6_locked", busy, 1'b1);
    cycle();
    rst   = 1'b1;
    allow = 4'b0011;
    drive();
    cycle();
    rst = 1'b0;
    check_eq("t6_mvalid", m_valid, 1'b0);
    check_eq("t6_busy", busy, 1'b0);
    m_ready = 1'b1;
    cycle();
    check_eq("t6_first", acc_src, 0);

    // Randomized traffic with random packet lengths, backpressure and occasional reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (tail[i] - head[i] < 4) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_beat(i, 8'($urandom), b == len - 1);
        end
      end
      allow   = NUM_SRC'($urandom | $urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      drive();
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
